bram_read_sched: RTL and testbench
==================================

// Module: bram_read_sched
// PURPOSE
//  Schedules PE source-operand reads onto the four single-port namespace BRAMs (DATA, WEIGHT, GRADIENT, META).
//  Serialises sources of one instruction that target the same namespace; different namespaces are read in parallel.
//  Captures the returned words per source and holds inst_stall_bram until every BRAM-sourced operand is captured.
//  Sits between the instruction decoder (srcN_decoder_out) and the PE ALU operand mux.
// PARAMETERS
//  srcNum   3   namespace-select width; decoder one-hot width is (1<<srcNum)
//  addrLen  8   namespace BRAM address width
//  dataLen  16  operand word width
// PORTS
//  clk              in   1            clock; all state on rising edge
//  reset            in   1            synchronous, active-high
//  inst_valid       in   1            current instruction valid
//  src0_decoder_out in   1<<srcNum    one-hot namespace of src0 (src1/src2 identical)
//  src0_addr        in   addrLen      BRAM address of src0 (src1/src2 identical)
//  ns_rd_en         out  4            read strobe: [0]DATA [1]WEIGHT [2]GRADIENT [3]META
//  ns_rd_addr       out  4*addrLen    per-namespace address, slice k = namespace k
//  ns_rd_data       in   4*dataLen    per-namespace read data, valid the cycle after ns_rd_en
//  src0_data        out  dataLen      captured operand (src1/src2 identical)
//  src_v_bram       out  3            bit n: srcN_data holds this instruction's BRAM operand
//  inst_stall_bram  out  1            stall the instruction pipeline
// BEHAVIOUR
//  - rq[n] = srcN_decoder_out has any of `NAMESPACE_DATA/WEIGHT/GRADIENT/META set.
//  - More than one BRAM namespace bit set per source is illegal; RTL uses the lowest of DATA<WEIGHT<GRADIENT<META.
//  - Reset: state IDLE, pend=0, inflight=0, ns_rd_en=0, ns_rd_addr=0, srcN_data=0, src_v_bram=0.
//  - Grant: per namespace, the lowest-index pending source wins (src0>src1>src2). At most one grant per namespace per cycle.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if inst_valid && rq!=0, grant from rq, drive ns_rd_en/addr the same cycle, pend<=rq&~grant, go BUSY.
//          If inst_valid && rq==0, no reads; stall stays 0.
//    BUSY: grant from pend; inflight<=grant (source of each issued read). The cycle after a read,
//          capture ns_rd_data of that source's namespace into srcN_data and set src_v_bram[n].
//          When pend==0 and the last capture is registered, go DONE.
//    DONE: exactly one cycle. src_v_bram==rq, inst_stall_bram=0, then clear src_v_bram and go IDLE.
//  - inst_stall_bram = inst_valid && rq!=0 && state!=DONE (combinational).
//  - Latency: inst_valid at cycle T with no conflicts -> reads at T, data registered at T+2, stall low at T+2.
//    k sources on one namespace add k-1 cycles; all three on one namespace -> stall low at T+4.
//  - Throughput: next instruction is sampled in IDLE the cycle after DONE.
//  - inst_valid falling while BUSY: abort. Next cycle IDLE, pend=0, src_v_bram=0, returning data discarded.
//  - Decoder inputs are held stable while stalled. RTL samples rq only in IDLE.
//  - reset mid-operation: next cycle matches the reset values, and ns_rd_en=0 that cycle.
// STRUCTURE
//  - Namespace indices come from inst.vh (`NAMESPACE_*); no new shared typedefs.
//  - Add BRAM_SCHED_IDLE/BUSY/DONE to inst.vh for the bench to probe.
//  - One sub-module, ns_prio_grant: 3-bit request, 3-bit one-hot fixed-priority grant.
//    Instantiated 4x, once per namespace, on (pend & source-targets-namespace-k).
// TESTING
//  1 reset=1 for 2 cycles with inst_valid=1 -> all outputs 0, ns_rd_en=0.
//  2 src0=DATA@0x05, src1=WEIGHT@0x10, src2=META@0x3F, inst_valid at T
//    -> ns_rd_en=4'b1011 at T; stall low only at T+2; src_v_bram=3'b111, data match the BRAM model.
//  3 all three DATA @0x01/0x02/0x03 -> ns_rd_en[0] high T..T+2 with addr 01,02,03 in order; stall low at T+4.
//  4 src0=DATA, src1=DATA, src2 non-BRAM -> two serial DATA reads; src_v_bram=3'b011 at T+3; stall never high after DONE.
//  5 no BRAM sources, inst_valid=1 -> stall=0 every cycle, ns_rd_en=0.
//  6 inst_valid drops at T+1 of scenario 3 -> T+2 IDLE, src_v_bram=0.
//    Next instruction (src0=GRADIENT@0x07) completes in 2 cycles with correct data.

Source files
------------

// File: rtl/bram_read_sched_pkg.sv
// Shared constants for the namespace BRAM read scheduler: decoder bit positions,
// namespace indices and scheduler FSM states.
package bram_read_sched_pkg;

    // Bit positions of the BRAM namespaces in a source's one-hot decoder output.
    localparam int DEC_DATA     = 1;
    localparam int DEC_WEIGHT   = 2;
    localparam int DEC_GRADIENT = 3;
    localparam int DEC_META     = 4;

    // Namespace index k used for ns_rd_en[k], ns_rd_addr slice k and ns_rd_data slice k.
    localparam int NS_DATA     = 0;
    localparam int NS_WEIGHT   = 1;
    localparam int NS_GRADIENT = 2;
    localparam int NS_META     = 3;
    localparam int NS_COUNT    = 4;

    typedef enum logic [1:0] {
        BRAM_SCHED_IDLE,
        BRAM_SCHED_BUSY,
        BRAM_SCHED_DONE
    } sched_state_t;

    // Multiple namespace hits are illegal; resolve to the lowest namespace.
    function automatic logic [1:0] lowest_ns(input logic [3:0] hits);
        if (hits[0]) begin
            return 2'd0;
        end else if (hits[1]) begin
            return 2'd1;
        end else if (hits[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/ns_prio_grant.sv
// Fixed-priority one-hot grant among the three sources competing for one namespace BRAM.
// Source 0 has the highest priority.
module ns_prio_grant (
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    assign gnt[0] = req[0];
    assign gnt[1] = req[1] & ~req[0];
    assign gnt[2] = req[2] & ~req[1] & ~req[0];

endmodule

// File: rtl/bram_read_sched.sv
// Schedules up to three source-operand reads onto the four single-port namespace BRAMs,
// serialising same-namespace conflicts and stalling until every BRAM operand is captured.
module bram_read_sched
    import bram_read_sched_pkg::*;
#(
    parameter int srcNum  = 3,
    parameter int addrLen = 8,
    parameter int dataLen = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inst_valid,
    input  logic [(1<<srcNum)-1:0]      src0_decoder_out,
    input  logic [(1<<srcNum)-1:0]      src1_decoder_out,
    input  logic [(1<<srcNum)-1:0]      src2_decoder_out,
    input  logic [addrLen-1:0]          src0_addr,
    input  logic [addrLen-1:0]          src1_addr,
    input  logic [addrLen-1:0]          src2_addr,
    output logic [3:0]                  ns_rd_en,
    output logic [NS_COUNT*addrLen-1:0] ns_rd_addr,
    input  logic [NS_COUNT*dataLen-1:0] ns_rd_data,
    output logic [dataLen-1:0]          src0_data,
    output logic [dataLen-1:0]          src1_data,
    output logic [dataLen-1:0]          src2_data,
    output logic [2:0]                  src_v_bram,
    output logic                        inst_stall_bram
);

    sched_state_t state;
    logic [2:0] pend;
    logic [2:0] inflight;
    logic [dataLen-1:0] src_data [3];

    logic [(1<<srcNum)-1:0] dec [3];
    logic [addrLen-1:0] addr [3];
    logic [2:0] rq;
    logic [1:0] ns_idx [3];
    logic [2:0] cand;
    logic active;
    logic [2:0] ns_req [NS_COUNT];
    logic [2:0] ns_gnt [NS_COUNT];
    logic [2:0] grant;
    logic unused_dec;

    assign dec[0]  = src0_decoder_out;
    assign dec[1]  = src1_decoder_out;
    assign dec[2]  = src2_decoder_out;
    assign addr[0] = src0_addr;
    assign addr[1] = src1_addr;
    assign addr[2] = src2_addr;
    assign unused_dec = ^{src0_decoder_out, src1_decoder_out, src2_decoder_out};

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            logic [3:0] hits;
            hits = {dec[n][DEC_META], dec[n][DEC_GRADIENT], dec[n][DEC_WEIGHT], dec[n][DEC_DATA]};
            rq[n] = |hits;
            ns_idx[n] = lowest_ns(hits);
        end
    end

    // Reads are only issued for a live instruction; reset and DONE never strobe a BRAM.
    assign active = inst_valid && !reset && (state != BRAM_SCHED_DONE);
    assign cand   = (state == BRAM_SCHED_IDLE) ? rq : pend;

    always_comb begin
        for (int k = 0; k < NS_COUNT; k++) begin
            ns_req[k] = '0;
            for (int n = 0; n < 3; n++) begin
                ns_req[k][n] = active && cand[n] && (ns_idx[n] == 2'(k));
            end
        end
    end

    for (genvar k = 0; k < NS_COUNT; k++) begin : g_ns
        ns_prio_grant u_grant (
            .req (ns_req[k]),
            .gnt (ns_gnt[k])
        );
    end

    always_comb begin
        grant      = '0;
        ns_rd_en   = '0;
        ns_rd_addr = '0;
        for (int k = 0; k < NS_COUNT; k++) begin
            ns_rd_en[k] = |ns_gnt[k];
            grant       = grant | ns_gnt[k];
            for (int n = 0; n < 3; n++) begin
                if (ns_gnt[k][n]) begin
                    ns_rd_addr[k*addrLen +: addrLen] = addr[n];
                end
            end
        end
    end

    assign inst_stall_bram = !reset && inst_valid && (rq != 3'b000) &&
                             (state != BRAM_SCHED_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BRAM_SCHED_IDLE;
            pend       <= '0;
            inflight   <= '0;
            src_v_bram <= '0;
            for (int n = 0; n < 3; n++) begin
                src_data[n] <= '0;
            end
        end else begin
            unique case (state)
                BRAM_SCHED_IDLE: begin
                    inflight   <= grant;
                    src_v_bram <= '0;
                    if (inst_valid && (rq != 3'b000)) begin
                        pend  <= rq & ~grant;
                        state <= BRAM_SCHED_BUSY;
                    end
                end
                BRAM_SCHED_BUSY: begin
                    if (!inst_valid) begin
                        // Abort: drop outstanding reads and anything returning this cycle.
                        state      <= BRAM_SCHED_IDLE;
                        pend       <= '0;
                        inflight   <= '0;
                        src_v_bram <= '0;
                    end else begin
                        for (int n = 0; n < 3; n++) begin
                            if (inflight[n]) begin
                                src_data[n]   <= ns_rd_data[ns_idx[n]*dataLen +: dataLen];
                                src_v_bram[n] <= 1'b1;
                            end
                        end
                        inflight <= grant;
                        pend     <= pend & ~grant;
                        if (pend == 3'b000) begin
                            state <= BRAM_SCHED_DONE;
                        end
                    end
                end
                BRAM_SCHED_DONE: begin
                    src_v_bram <= '0;
                    inflight   <= '0;
                    state      <= BRAM_SCHED_IDLE;
                end
                default: state <= BRAM_SCHED_IDLE;
            endcase
        end
    end

    assign src0_data = src_data[0];
    assign src1_data = src_data[1];
    assign src2_data = src_data[2];

endmodule

// File: tb/tb_bram_read_sched.sv
// Scoreboard bench for bram_read_sched: driver queues expected reads and responses,
// monitors compare whenever the DUT strobes a BRAM or completes an instruction.
module tb_bram_read_sched;
    import bram_read_sched_pkg::*;

    localparam logic [7:0] D_NONE = 8'h01;
    localparam logic [7:0] D_DATA = 8'(1 << DEC_DATA);
    localparam logic [7:0] D_WGT  = 8'(1 << DEC_WEIGHT);
    localparam logic [7:0] D_GRAD = 8'(1 << DEC_GRADIENT);
    localparam logic [7:0] D_META = 8'(1 << DEC_META);

    logic clk = 1'b0;
    logic reset, inst_valid;
    logic [7:0] src0_dec, src1_dec, src2_dec;
    logic [7:0] src0_addr, src1_addr, src2_addr;
    logic [3:0] ns_rd_en;
    logic [31:0] ns_rd_addr;
    logic [63:0] ns_rd_data;
    logic [15:0] src0_data, src1_data, src2_data;
    logic [2:0] src_v_bram;
    logic inst_stall_bram;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] addr;
    } rd_t;
    typedef struct {
        logic [2:0]  v;
        logic [15:0] d0, d1, d2;
        int          cyc;
    } resp_t;
    rd_t   rd_q[$];
    resp_t resp_q[$];

    bram_read_sched dut (
        .clk              (clk),
        .reset            (reset),
        .inst_valid       (inst_valid),
        .src0_decoder_out (src0_dec),
        .src1_decoder_out (src1_dec),
        .src2_decoder_out (src2_dec),
        .src0_addr        (src0_addr),
        .src1_addr        (src1_addr),
        .src2_addr        (src2_addr),
        .ns_rd_en         (ns_rd_en),
        .ns_rd_addr       (ns_rd_addr),
        .ns_rd_data       (ns_rd_data),
        .src0_data        (src0_data),
        .src1_data        (src1_data),
        .src2_data        (src2_data),
        .src_v_bram       (src_v_bram),
        .inst_stall_bram  (inst_stall_bram)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: word = {namespace+1, 4'hA, addr}; unread namespaces return junk.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ns_rd_en[k]) ns_rd_data[k*16 +: 16] <= {4'(k + 1), 4'hA, ns_rd_addr[k*8 +: 8]};
            else             ns_rd_data[k*16 +: 16] <= 16'hDEAD;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read monitor
    always @(negedge clk) begin
        if (ns_rd_en !== 4'b0000) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", {28'd0, ns_rd_en}, 64'd0);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                check("rd_en", {60'd0, ns_rd_en}, {60'd0, e.en});
                check("rd_addr", {32'd0, ns_rd_addr}, {32'd0, e.addr});
            end
        end
    end

    // Completion monitor: instruction finishes when a valid BRAM instruction releases its stall.
    always @(negedge clk) begin
        if (inst_valid && !inst_stall_bram && src_v_bram !== 3'b000) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", {61'd0, src_v_bram}, 64'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("resp_v", {61'd0, src_v_bram}, {61'd0, e.v});
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                if (e.v[0]) check("src0_data", {48'd0, src0_data}, {48'd0, e.d0});
                if (e.v[1]) check("src1_data", {48'd0, src1_data}, {48'd0, e.d1});
                if (e.v[2]) check("src2_data", {48'd0, src2_data}, {48'd0, e.d2});
            end
        end
    end

    task automatic expect_read(input logic [3:0] en, input logic [31:0] addr);
        rd_t r;
        r.en = en;
        r.addr = addr;
        rd_q.push_back(r);
    endtask

    task automatic expect_resp(input logic [2:0] v, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input int lat);
        resp_t r;
        r.v = v;
        r.d0 = d0;
        r.d1 = d1;
        r.d2 = d2;
        r.cyc = cyc + lat;
        resp_q.push_back(r);
    endtask

    task automatic set_src(input logic [7:0] d0, input logic [7:0] a0, input logic [7:0] d1,
                           input logic [7:0] a1, input logic [7:0] d2, input logic [7:0] a2);
        src0_dec = d0; src0_addr = a0;
        src1_dec = d1; src1_addr = a1;
        src2_dec = d2; src2_addr = a2;
    endtask

    // Present one instruction and hold it until the stall drops; lat = expected stall cycles.
    task automatic issue(input logic [7:0] d0, input logic [7:0] a0, input logic [7:0] d1,
                         input logic [7:0] a1, input logic [7:0] d2, input logic [7:0] a2,
                         input int lat);
        int stalls = 0;
        set_src(d0, a0, d1, a1, d2, a2);
        inst_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (!inst_stall_bram) break;
            stalls++;
            if (stalls > 20) begin
                check("stall_timeout", 64'(stalls), 64'(lat));
                break;
            end
        end
        check("stall_cycles", 64'(stalls), 64'(lat));
        @(posedge clk); #1;
        inst_valid = 1'b0;
        set_src(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_valid = 1'b1;
        set_src(D_DATA, 8'h05, D_DATA, 8'h06, D_META, 8'h07);
        repeat (2) begin
            @(negedge clk);
            check("rst_rd_en", {60'd0, ns_rd_en}, 64'd0);
            check("rst_rd_addr", {32'd0, ns_rd_addr}, 64'd0);
            check("rst_stall", {63'd0, inst_stall_bram}, 64'd0);
            check("rst_src_v", {61'd0, src_v_bram}, 64'd0);
            check("rst_data", {16'd0, src0_data, src1_data, src2_data}, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        inst_valid = 1'b0;
        set_src(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst_state", 64'(dut.state), 64'(BRAM_SCHED_IDLE));

        // Three namespaces in parallel
        expect_read(4'b1011, 32'h3F00_1005);
        expect_resp(3'b111, 16'h1A05, 16'h2A10, 16'h4A3F, 2);
        issue(D_DATA, 8'h05, D_WGT, 8'h10, D_META, 8'h3F, 2);

        // All three on DATA, serialised in source order
        expect_read(4'b0001, 32'h0000_0001);
        expect_read(4'b0001, 32'h0000_0002);
        expect_read(4'b0001, 32'h0000_0003);
        expect_resp(3'b111, 16'h1A01, 16'h1A02, 16'h1A03, 4);
        issue(D_DATA, 8'h01, D_DATA, 8'h02, D_DATA, 8'h03, 4);

        // Two DATA sources plus a non-BRAM source
        expect_read(4'b0001, 32'h0000_0020);
        expect_read(4'b0001, 32'h0000_0021);
        expect_resp(3'b011, 16'h1A20, 16'h1A21, 16'h0000, 3);
        issue(D_DATA, 8'h20, D_DATA, 8'h21, D_NONE, 8'h55, 3);

        // No BRAM sources
        issue(D_NONE, 8'h11, D_NONE, 8'h12, 8'h00, 8'h13, 0);

        // Illegal multi-hit resolves to the lowest namespace; src1 on GRADIENT alongside
        expect_read(4'b0110, 32'h0044_2200);
        expect_resp(3'b011, 16'h2A22, 16'h3A44, 16'h0000, 2);
        issue(D_WGT | D_META, 8'h22, D_GRAD, 8'h44, D_NONE, 8'h00, 2);

        // Abort: inst_valid drops one cycle into the all-DATA instruction
        expect_read(4'b0001, 32'h0000_0001);
        set_src(D_DATA, 8'h01, D_DATA, 8'h02, D_DATA, 8'h03);
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_state", 64'(dut.state), 64'(BRAM_SCHED_IDLE));
        check("abort_src_v", {61'd0, src_v_bram}, 64'd0);
        expect_read(4'b0100, 32'h0007_0000);
        expect_resp(3'b001, 16'h3A07, 16'h0000, 16'h0000, 2);
        issue(D_GRAD, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 2);

        // Reset in the middle of a serialised instruction
        expect_read(4'b0001, 32'h0000_0001);
        set_src(D_DATA, 8'h01, D_DATA, 8'h02, D_DATA, 8'h03);
        inst_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rd_en", {60'd0, ns_rd_en}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        inst_valid = 1'b0;
        set_src(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst_state", 64'(dut.state), 64'(BRAM_SCHED_IDLE));
        check("midrst_src_v", {61'd0, src_v_bram}, 64'd0);
        check("midrst_data", {16'd0, src0_data, src1_data, src2_data}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
